// File: rtl/match_window_counter_pkg.sv
// Shared definitions for the match window counter: FSM state encoding and
// default widths for the window timer and match count.
package match_window_counter_pkg;

    localparam int DEF_WIN_W = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage : match_window_counter_pkg

// File: rtl/match_window_counter_win_timer.sv
// Window timer: loads a window length, counts down once per cycle and flags
// the last cycle of the window. A load value of 0 wraps through all-ones, so
// it naturally yields a window of 2^W cycles.
module win_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] timer;

    // Load has priority over decrement so a restart always begins a fresh window.
    always_ff @(posedge clk or posedge clr) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (clr) begin
            timer <= '0;
        end else if (load) begin
            timer <= load_val;
        end else if (dec) begin
            timer <= timer - W'(1);
        end
    end

    assign last = (timer == W'(1));

endmodule : win_timer

// File: rtl/match_window_counter.sv
// Match window counter: counts single-cycle hits from an upstream sequence
// detector over a programmable window, then holds the result (count plus
// saturation flag) until the consumer acknowledges it.
module match_window_counter
    import match_window_counter_pkg::*;
#(
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIN_W-1:0] win_len,
    input  logic             hit,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ack,
    output logic             ovf
);

    state_t           state;
    logic [CNT_W-1:0] run_cnt;
    logic             run_ovf;

    logic             timer_load;
    logic             timer_dec;
    logic             timer_last;

    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    // A window starts from IDLE, or directly from REPORT when the result is
    // acknowledged while still enabled (back-to-back windows).
    assign timer_load = en && ((state == IDLE) || ((state == REPORT) && cnt_ack));
    assign timer_dec  = (state == COUNT);

    win_timer #(
        .W (WIN_W)
    ) u_win_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (timer_load),
        .load_val (win_len),
        .dec      (timer_dec),
        .last     (timer_last)
    );

    // Saturating increment of the running count; a hit at full scale sets overflow.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_next = run_cnt;
        ovf_next = run_ovf;
        if (hit) begin
            if (run_cnt == {CNT_W{1'b1}}) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = run_cnt + CNT_W'(1);
            end
        end
    end

    // Window FSM with inline running counter and registered result outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            run_cnt   <= '0;
            run_ovf   <= 1'b0;
            cnt_out   <= '0;
            cnt_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Hits are ignored here; only a window start matters.
                    if (en) begin
                        run_cnt <= '0;
                        run_ovf <= 1'b0;
                        state   <= COUNT;
                    end
                end

                COUNT: begin
                    if (!en) begin
                        // Abort: the partial window is dropped, the last
                        // reported result stays on the outputs.
                        state <= IDLE;
                    end else if (timer_last) begin
                        // The last window cycle's hit is folded into the result.
                        cnt_out   <= cnt_next;
                        ovf       <= ovf_next;
                        cnt_valid <= 1'b1;
                        state     <= REPORT;
                    end else begin
                        run_cnt <= cnt_next;
                        run_ovf <= ovf_next;
                    end
                end

                REPORT: begin
                    // Dead time: the result is held until acknowledged, even
                    // if en drops, so a result is never lost.
                    if (cnt_ack) begin
                        cnt_valid <= 1'b0;
                        if (en) begin
                            run_cnt <= '0;
                            run_ovf <= 1'b0;
                            state   <= COUNT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : match_window_counter

// File: tb/tb_match_window_counter.sv
// Self-checking bench for match_window_counter. The reference model works at
// the window level: the expected result is the number of hits presented over
// the effective window length, clipped to the count range, with overflow set
// when more hits arrived than the count can hold.
module tb_match_window_counter;
    import match_window_counter_pkg::*;

    localparam int WIN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             clr;
    logic             en;
    logic [WIN_W-1:0] win_len;
    logic             hit;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_valid;
    logic             cnt_ack;
    logic             ovf;

    int errors;
    int checks;

    // Last result the model expects to see on cnt_out / ovf.
    int   exp_out;
    logic exp_ovf;

    match_window_counter #(
        .WIN_W (WIN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .win_len   (win_len),
        .hit       (hit),
        .cnt_out   (cnt_out),
        .cnt_valid (cnt_valid),
        .cnt_ack   (cnt_ack),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runs one window from a negedge: in IDLE or REPORT, en=1 with ack=1
    // starts it on the next edge. Checks cnt_valid stays low for exactly
    // len edges after the start edge (inclusive count: rises on edge len+1)
    // and then checks the reported result against the model.
    task automatic run_window(input int len, input logic [15:0] pat);
        int l_eff;
        int total;
        l_eff   = (len == 0) ? (1 << WIN_W) : len;
        total   = 0;
        en      = 1'b1;
        cnt_ack = 1'b1;
        win_len = WIN_W'(len);
        hit     = 1'($urandom_range(0, 1));
        for (int i = 1; i <= l_eff; i++) begin
            @(negedge clk);
            checks++;
            if (cnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL early_valid t=%0t len=%0d cycle=%0d got=%b exp=0",
                         $time, len, i, cnt_valid);
            end
            cnt_ack = 1'($urandom_range(0, 1));
            win_len = WIN_W'($urandom_range(0, 15));
            hit     = pat[i-1];
            if (pat[i-1]) total++;
        end
        @(negedge clk);
        hit     = 1'($urandom_range(0, 1));
        cnt_ack = 1'b0;
        exp_out = (total > CNT_MAX) ? CNT_MAX : total;
        exp_ovf = (total > CNT_MAX);
        checks++;
        if (cnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL report_valid t=%0t len=%0d got=%b exp=1", $time, len, cnt_valid);
        end
        checks++;
        if (cnt_out !== CNT_W'(exp_out)) begin
            errors++;
            $display("FAIL report_cnt t=%0t len=%0d got=%0d exp=%0d", $time, len, cnt_out, exp_out);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL report_ovf t=%0t len=%0d got=%b exp=%b", $time, len, ovf, exp_ovf);
        end
    endtask

    // Holds a pending result for n cycles without ack, with hits and en noise.
    task automatic hold_report(input int n);
        for (int i = 0; i < n; i++) begin
            hit     = 1'($urandom_range(0, 1));
            en      = 1'($urandom_range(0, 1));
            cnt_ack = 1'b0;
            @(negedge clk);
            checks++;
            if (cnt_valid !== 1'b1 || cnt_out !== CNT_W'(exp_out) || ovf !== exp_ovf) begin
                errors++;
                $display("FAIL hold_stable t=%0t got v=%b c=%0d o=%b exp v=1 c=%0d o=%b",
                         $time, cnt_valid, cnt_out, ovf, exp_out, exp_ovf);
            end
        end
    endtask

    // Acknowledges with en=0: valid must clear and the FSM must idle.
    task automatic ack_to_idle();
        cnt_ack = 1'b1;
        en      = 1'b0;
        @(negedge clk);
        cnt_ack = 1'b0;
        checks++;
        if (cnt_valid !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL ack_idle t=%0t got v=%b st=%0d exp v=0 st=0",
                     $time, cnt_valid, dut.state);
        end
    endtask

    task automatic test_reset();
        clr     = 1'b0;
        en      = 1'b0;
        win_len = '0;
        hit     = 1'b0;
        cnt_ack = 1'b0;
        #2 clr = 1'b1;
        #1;
        checks++;
        if (cnt_out !== '0 || cnt_valid !== 1'b0 || ovf !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got c=%0d v=%b o=%b st=%0d exp all 0",
                     cnt_out, cnt_valid, ovf, dut.state);
        end
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        repeat (3) begin
            hit = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checks++;
        if (cnt_valid !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL idle_no_en got v=%b st=%0d exp v=0 st=0", cnt_valid, dut.state);
        end
        exp_out = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic test_basic();
        run_window(5, 16'h0009);
    endtask

    task automatic test_hold_back_to_back();
        hold_report(10);
        run_window(3, 16'h0007);
        ack_to_idle();
    endtask

    task automatic test_saturate();
        run_window(8, 16'h00FF);
    endtask

    task automatic test_abort();
        en      = 1'b1;
        cnt_ack = 1'b1;
        win_len = WIN_W'(5);
        hit     = 1'b0;
        @(negedge clk);
        cnt_ack = 1'b0;
        hit     = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        @(negedge clk);
        en  = 1'b0;
        hit = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            hit     = 1'($urandom_range(0, 1));
            cnt_ack = 1'($urandom_range(0, 1));
            checks++;
            if (cnt_valid !== 1'b0 || cnt_out !== CNT_W'(exp_out) || ovf !== exp_ovf) begin
                errors++;
                $display("FAIL abort_hold t=%0t got v=%b c=%0d o=%b exp v=0 c=%0d o=%b",
                         $time, cnt_valid, cnt_out, ovf, exp_out, exp_ovf);
            end
        end
        cnt_ack = 1'b0;
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL abort_state got=%0d exp=0", dut.state);
        end
    endtask

    task automatic test_win0();
        run_window(0, 16'h8001);
    endtask

    task automatic test_clr_async();
        // Mid-COUNT: a result of 2 is on the outputs, a partial count is running.
        en      = 1'b1;
        cnt_ack = 1'b1;
        win_len = WIN_W'(10);
        hit     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cnt_ack = 1'b0;
            hit     = 1'b1;
        end
        #2;
        clr = 1'b1;
        en  = 1'b0;
        hit = 1'b0;
        #1;
        checks++;
        if (cnt_valid !== 1'b0 || cnt_out !== '0 || ovf !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL clr_count got v=%b c=%0d o=%b st=%0d exp all 0",
                     cnt_valid, cnt_out, ovf, dut.state);
        end
        @(negedge clk);
        clr     = 1'b0;
        exp_out = 0;
        exp_ovf = 1'b0;
        run_window(4, 16'h0002);
        run_window(8, 16'h00FF);
        // Mid-REPORT: a saturated result is pending.
        #2;
        clr = 1'b1;
        en  = 1'b0;
        #1;
        checks++;
        if (cnt_valid !== 1'b0 || cnt_out !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_report got v=%b c=%0d o=%b exp all 0", cnt_valid, cnt_out, ovf);
        end
        @(negedge clk);
        clr     = 1'b0;
        exp_out = 0;
        exp_ovf = 1'b0;
        run_window(2, 16'h0003);
    endtask

    task automatic test_random();
        logic [15:0] pat;
        for (int w = 0; w < 30; w++) begin
            for (int b = 0; b < 16; b++) begin
                pat[b] = ($urandom_range(0, 3) == 0);
            end
            run_window(int'($urandom_range(0, 15)), pat);
            hold_report(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) begin
                ack_to_idle();
                repeat (int'($urandom_range(0, 3))) begin
                    hit = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_hold_back_to_back();
        test_saturate();
        test_abort();
        test_win0();
        test_clr_async();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_match_window_counter

// File: doc/match_window_counter.md
MATCH_WINDOW_COUNTER -- requirements
Module: match_window_counter

Interface
REQ-001 SHALL have parameter WIN_W, default 8: width of the window-length input and the window timer.
REQ-002 SHALL have parameter CNT_W, default 8: width of the match count.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: enable; 1 = run windows, 0 = abort and idle.
REQ-006 SHALL have port win_len, input, WIN_W bits: window length in clk cycles, sampled at window start.
REQ-007 SHALL have port hit, input, 1 bit: single-cycle match indication from the upstream 1010 sequence detector output.
REQ-008 SHALL have port cnt_out, output, CNT_W bits: matches counted in the last completed window.
REQ-009 SHALL have port cnt_valid, output, 1 bit: cnt_out and ovf hold a result awaiting acknowledge.
REQ-010 SHALL have port cnt_ack, input, 1 bit: consumer acknowledge of the current result.
REQ-011 SHALL have port ovf, output, 1 bit: count saturated during the reported window.

Function
REQ-012 SHALL implement states IDLE, COUNT and REPORT.
REQ-013 IDLE: when en=1, SHALL load the timer with win_len (0 means 2^WIN_W cycles), clear the running count and overflow, and go to COUNT on the next edge.
REQ-014 IDLE: hit SHALL be ignored.
REQ-015 COUNT: each cycle with hit=1 SHALL increment the running count, including the first and last window cycles.
REQ-016 COUNT: the timer SHALL decrement once per cycle.
REQ-017 The running count SHALL saturate at 2^CNT_W-1; a hit at saturation SHALL set the window overflow flag.
REQ-018 COUNT, last window cycle (timer = 1): the next edge SHALL register the final count into cnt_out and the overflow into ovf, set cnt_valid=1, and enter REPORT.
REQ-019 Latency: cnt_valid SHALL rise exactly win_len+1 edges after the IDLE edge that saw en=1.
REQ-020 COUNT with en=0: SHALL abort to IDLE on the next edge, produce no report, and leave cnt_out/ovf unchanged.
REQ-021 REPORT: cnt_valid, cnt_out and ovf SHALL stay stable until cnt_ack=1 is sampled.
REQ-022 REPORT: hits SHALL not be counted (dead time).
REQ-023 REPORT, cnt_ack=1 and en=1: SHALL clear cnt_valid and restart COUNT with a fresh win_len load on the same edge.
REQ-024 REPORT, cnt_ack=1 and en=0: SHALL clear cnt_valid and go to IDLE.
REQ-025 REPORT, en=0 without ack: SHALL keep the result; the result is never dropped.
REQ-026 cnt_ack while cnt_valid=0 SHALL be ignored.
REQ-027 A change of win_len mid-window SHALL not affect the current window.

Reset
REQ-028 clr=1 SHALL immediately force IDLE, cnt_out=0, cnt_valid=0, ovf=0, timer=0 and running count=0, independent of clk.
REQ-029 Reset asserted mid-COUNT or mid-REPORT SHALL discard all partial and pending results.
REQ-030 After clr deasserts, the first window SHALL start per REQ-013.

Structure
REQ-031 The state encoding (IDLE=0, COUNT=1, REPORT=2) and the default WIN_W/CNT_W values SHALL live in a shared package.
REQ-032 The window timer SHALL be a sub-module win_timer (load, decrement, last-cycle flag); the counter and FSM SHALL be inline.

Verification
REQ-033 win_len=5, en=1, hit high on window cycles 1 and 4 -> cnt_valid rises 6 edges after start with cnt_out=2, ovf=0.
REQ-034 CNT_W=2, win_len=8, hit=1 every cycle -> cnt_out=3, ovf=1.
REQ-035 Result pending, cnt_ack held 0 for 10 cycles with hits present -> cnt_out unchanged; then ack with en=1 -> cnt_valid=0 and the next window begins that edge.
REQ-036 en dropped on window cycle 3 of 5 -> no cnt_valid, state IDLE, prior cnt_out retained.
REQ-037 clr pulsed mid-COUNT and again mid-REPORT, asynchronously to clk -> outputs 0 immediately.
REQ-038 win_len=0, WIN_W=4 -> report after 16 window cycles; a hit on the final cycle is counted.
